bk_pipelined_subtractor: RTL and testbench
==========================================

Name: bk_pipelined_subtractor

Overview:
- 3-stage pipelined Brent-Kung prefix subtractor: computes in_op1 - in_op2 - in_bin.
- Inverse-direction companion to the combinational Brent-Kung adder in the datapath library.
- Valid/ready streaming on input and output; full throughput with backpressure.
- Sits between the operand-fetch stage and the result writeback stage of the datapath.

Parameters:
WIDTH, `ADDER_SIZE (32), operand/result width; must be a power of two, >= 4
TAG_W, 4, width of sideband tag carried alongside each operation

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  subtractor can accept a beat this cycle
in_op1  input  WIDTH  minuend
in_op2  input  WIDTH  subtrahend
in_bin  input  1  borrow-in
in_tag  input  TAG_W  sideband, returned unchanged with result
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_res  output  WIDTH  difference, modulo 2^WIDTH
out_bout  output  1  borrow-out (1 = unsigned underflow)
out_ovf  output  1  signed two's-complement overflow
out_zero  output  1  out_res == 0
out_tag  output  TAG_W  tag of this result

Behaviour:
- Arithmetic: out_res = in_op1 + ~in_op2 + ~in_bin.
  - Stage-0 propagate P = op1 ^ ~op2; generate G = op1 & ~op2; prefix carry-in C0 = ~in_bin.
  - out_bout = ~carry_out.
  - out_ovf = (op1[MSB] != op2[MSB]) && (res[MSB] != op1[MSB]).
- Stage S1 (captured on input handshake): registers P, G, C0, op1[MSB], op2[MSB], tag.
- Stage S2: Brent-Kung up-sweep (log2(WIDTH) levels of black cells), with C0 folded in as bit -1 generate. Registers group G/P tree nodes.
- Stage S3: down-sweep fills all bit carries; sum = P ^ carries; flags computed; registered into the output stage.
- Latency: 3 cycles from in handshake to out_valid, with no stall.
- Throughput: 1 op/cycle when out_ready stays high.
- Handshake:
  - Each stage has a valid bit v1..v3.
  - Stage k loads when !v_k || advance_k, where advance_3 = out_ready.
  - in_ready = !v1 || advance_1, a combinational chain back from out_ready.
  - Transfer occurs iff valid && ready on either side.
- Output hold: while out_valid && !out_ready, out_res, out_bout, out_ovf, out_zero and out_tag stay stable. Stalled stages keep their contents.
- Bubbles: a bubble in any stage collapses when the next stage is empty, even under downstream stall. Up to 3 ops are held in flight.
- Simultaneous events:
  - A full pipe with out_ready = 1 and in_valid = 1 shifts all stages in the same cycle.
  - The input is accepted; nothing is lost or duplicated.
- Reset (async assert, sync deassert handled externally):
  - v1..v3 = 0, so out_valid = 0.
  - out_res, out_tag, out_bout, out_ovf = 0; out_zero = 0.
  - in_ready = 1 once out of reset.
- Reset mid-operation: all in-flight ops are discarded and no result is emitted for them.
- Data registers need no reset except the output stage; valid bits must be reset.
- Order is preserved: results emerge in input order with the matching tag.

Decomposition:
- Shared package bk_pkg:
  - typedef pg_t: struct {logic g; logic p;}
  - localparam LOG2_W = $clog2(`ADDER_SIZE)
  - function pg_combine(hi, lo) = {hi.g | (hi.p & lo.g), hi.p & lo.p}
- One sub-module, bk_black_cell: combinational prefix cell (g_hi, p_hi, g_lo, p_lo -> g_out, p_out).
  - Instantiated in generate loops for the up-sweep and down-sweep.
- Pipeline valid/ready control stays in the top module.

Test Plan:
- Basic: op1=0x0000_000A, op2=0x0000_0003, bin=0, tag=5.
  - Expect after 3 cycles: res=0x0000_0007, bout=0, ovf=0, zero=0, tag=5.
- Underflow and borrow-in: op1=0, op2=0, bin=1 -> res=0xFFFF_FFFF, bout=1, ovf=0.
  - Also op1=0x5, op2=0x5, bin=0 -> res=0, zero=1.
- Signed overflow: op1=0x8000_0000, op2=0x0000_0001 -> res=0x7FFF_FFFF, ovf=1, bout=0.
  - Also op1=0x7FFF_FFFF, op2=0xFFFF_FFFF -> res=0x8000_0000, ovf=1, bout=1.
- Backpressure: stream 6 ops (tags 0..5) with in_valid held high and out_ready=0 for 5 cycles.
  - in_ready drops after 3 accepts; outputs stay stable.
  - On release, all 6 results arrive in tag order, with no loss or duplication.
- Full-carry chain: op1=0x0000_0000, op2=0xFFFF_FFFF, bin=0 -> res=0x0000_0001, bout=1.
  - Plus 10k random ops checked against a reference model, with random in_valid/out_ready.
- Reset mid-flight: assert rst_n=0 with 3 ops in flight.
  - out_valid=0 immediately; no stale results after release.
  - The next op produces the correct result at latency 3.

Source files
------------

// File: rtl/bk_pipelined_subtractor_pkg.sv
// bk_pkg: shared generate/propagate types and prefix helpers for the Brent-Kung datapath
`ifndef ADDER_SIZE
`define ADDER_SIZE 32
`endif
package bk_pkg;
    typedef struct packed {
        logic g;
        logic p;
    } pg_t;
    localparam int LOG2_W = $clog2(`ADDER_SIZE);
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        return '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
    endfunction
endpackage

// File: rtl/bk_pipelined_subtractor_black_cell.sv
// bk_black_cell: combinational Brent-Kung prefix cell merging a high and a low group
module bk_black_cell
    import bk_pkg::*;
(
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);
    pg_t r;
    assign r = pg_combine('{g: g_hi, p: p_hi}, '{g: g_lo, p: p_lo});
    assign g_out = r.g;
    assign p_out = r.p;
endmodule

// File: rtl/bk_pipelined_subtractor.sv
// bk_pipelined_subtractor: 3-stage Brent-Kung prefix subtractor, op1 - op2 - bin, valid/ready on both sides
`ifndef ADDER_SIZE
`define ADDER_SIZE 32
`endif
module bk_pipelined_subtractor
    import bk_pkg::*;
#(
    parameter int WIDTH = `ADDER_SIZE,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic             in_bin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_bout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int L = $clog2(WIDTH);
    logic v1, v2, v3, ld1, ld2, ld3;
    assign ld3 = !v3 || out_ready;
    assign ld2 = !v2 || ld3;
    assign ld1 = !v1 || ld2;
    assign in_ready = ld1;
    assign out_valid = v3;
    logic [WIDTH-1:0] p1, g1;
    logic c1, a1, b1;
    logic [TAG_W-1:0] t1;
    always_ff @(posedge clk) begin
        if (ld1) begin
            p1 <= in_op1 ^ ~in_op2;
            g1 <= in_op1 & ~in_op2;
            c1 <= ~in_bin;
            a1 <= in_op1[WIDTH-1];
            b1 <= in_op2[WIDTH-1];
            t1 <= in_tag;
        end
    end
    // carry-in enters as a generate-only group below bit 0
    pg_t f;
    logic [WIDTH-1:0] ug [0:L];
    logic [WIDTH-1:0] up [0:L];
    assign f = pg_combine('{g: g1[0], p: p1[0]}, '{g: c1, p: 1'b0});
    assign ug[0] = {g1[WIDTH-1:1], f.g};
    assign up[0] = {p1[WIDTH-1:1], f.p};
    for (genvar i = 0; i < L; i++) begin : g_up
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            if ((j + 1) % (2 ** (i + 1)) == 0) begin : g_cell
                bk_black_cell u_cell (
                    .g_hi(ug[i][j]), .p_hi(up[i][j]),
                    .g_lo(ug[i][j-2**i]), .p_lo(up[i][j-2**i]),
                    .g_out(ug[i+1][j]), .p_out(up[i+1][j])
                );
            end else begin : g_pass
                assign ug[i+1][j] = ug[i][j];
                assign up[i+1][j] = up[i][j];
            end
        end
    end
    logic [WIDTH-1:0] ug2, up2, s2;
    logic c2, a2, b2;
    logic [TAG_W-1:0] t2;
    always_ff @(posedge clk) begin
        if (ld2) begin
            ug2 <= ug[L];
            up2 <= up[L];
            s2 <= p1;
            c2 <= c1;
            a2 <= a1;
            b2 <= b1;
            t2 <= t1;
        end
    end
    // down-sweep: fill carries at 3*2^i-1 + k*2^(i+1) from the coarser level
    logic [WIDTH-1:0] dg [0:L-1];
    logic [WIDTH-1:0] dp [0:L-1];
    assign dg[L-1] = ug2;
    assign dp[L-1] = up2;
    for (genvar i = 0; i < L - 1; i++) begin : g_dn
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            if ((j + 1) % (2 ** (i + 1)) == 2 ** i && j >= 2 ** (i + 1)) begin : g_cell
                bk_black_cell u_cell (
                    .g_hi(dg[i+1][j]), .p_hi(dp[i+1][j]),
                    .g_lo(dg[i+1][j-2**i]), .p_lo(dp[i+1][j-2**i]),
                    .g_out(dg[i][j]), .p_out(dp[i][j])
                );
            end else begin : g_pass
                assign dg[i][j] = dg[i+1][j];
                assign dp[i][j] = dp[i+1][j];
            end
        end
    end
    logic unused_p;
    logic [WIDTH-1:0] sum;
    assign unused_p = ^dp[0];
    assign sum = s2 ^ {dg[0][WIDTH-2:0], c2};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            out_res <= '0;
            out_bout <= 1'b0;
            out_ovf <= 1'b0;
            out_zero <= 1'b0;
            out_tag <= '0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
            if (ld3 && v2) begin
                out_res <= sum;
                out_bout <= ~dg[0][WIDTH-1];
                out_ovf <= (a2 != b2) && (sum[WIDTH-1] != a2);
                out_zero <= sum == '0;
                out_tag <= t2;
            end
        end
    end
endmodule

// File: tb/tb_bk_pipelined_subtractor.sv
// tb_bk_pipelined_subtractor: directed and random scoreboard bench for the pipelined subtractor
module tb_bk_pipelined_subtractor;
    localparam int W = 32;
    localparam int TW = 4;
    typedef logic [W+TW+2:0] exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_bin = 1'b0;
    logic [W-1:0] in_op1 = '0, in_op2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic out_valid, out_ready = 1'b1, out_bout, out_ovf, out_zero;
    logic [W-1:0] out_res;
    logic [TW-1:0] out_tag;
    exp_t sb[$];
    int checks = 0, errs = 0, n_in = 0, n_out = 0;
    int k, acc, sent;
    bit fired, stale;
    logic [W+TW-1:0] held;

    always #5 clk = ~clk;

    bk_pipelined_subtractor #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_bin(in_bin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_bout(out_bout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic bi, logic [TW-1:0] t);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        return {d[W-1:0], d[W], (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), d[W-1:0] == '0, t};
    endfunction

    task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic bi, logic [TW-1:0] t);
        bit ok;
        in_op1 = a;
        in_op2 = b;
        in_bin = bi;
        in_tag = t;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            cyc();
        end
        check("send_accept", 64'(ok), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic set_op(int i);
        in_op1 = 32'h1111_1111 * W'(i);
        in_op2 = 32'd7;
        in_bin = i[0];
        in_tag = TW'(i);
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && sb.size() != 0; n++) cyc();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // scoreboard: push at input handshake, pop and compare at output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb.push_back(model(in_op1, in_op2, in_bin, in_tag));
                n_in++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                check("out_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0)
                    check("result", 64'({out_res, out_bout, out_ovf, out_zero, out_tag}), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({out_res, out_bout, out_ovf, out_zero, out_tag}), 64'd0);
        cyc();
        rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        send(32'h0000_000A, 32'h0000_0003, 1'b0, 4'd5);
        cyc();
        check("lat_not_yet", 64'(out_valid), 64'd0);
        cyc();
        check("lat_three", 64'(out_valid), 64'd1);
        check("basic_res", 64'(out_res), 64'h7);
        drain();

        send(32'h0000_0000, 32'h0000_0000, 1'b1, 4'd1);
        send(32'h0000_0005, 32'h0000_0005, 1'b0, 4'd2);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 4'd3);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd4);
        send(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 4'd6);
        drain();

        out_ready = 1'b0;
        k = 0;
        acc = 0;
        set_op(0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            fired = in_ready;
            if (c == 3) begin
                held = {out_res, out_tag};
                check("bp_out_valid", 64'(out_valid), 64'd1);
            end
            if (c == 4) begin
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_accepts", 64'(acc), 64'd3);
                check("bp_hold", 64'({out_res, out_tag}), 64'(held));
            end
            if (fired) acc++;
            cyc();
            if (fired) begin
                k++;
                set_op(k);
            end
        end
        out_ready = 1'b1;
        for (int n = 0; n < 100 && k < 6; n++) begin
            @(negedge clk);
            fired = in_ready;
            cyc();
            if (fired) begin
                k++;
                set_op(k);
            end
        end
        in_valid = 1'b0;
        check("bp_all_sent", 64'(k), 64'd6);
        drain();
        check("bp_no_loss_dup", 64'(n_out), 64'(n_in));

        sent = 0;
        for (int n = 0; n < 60000 && sent < 10000; n++) begin
            @(negedge clk);
            fired = in_valid && in_ready;
            cyc();
            if (fired) sent++;
            if (fired || !in_valid) begin
                in_valid = ($urandom % 4) != 0;
                in_op1 = $urandom;
                in_op2 = ($urandom % 8 == 0) ? in_op1 : $urandom;
                in_bin = 1'($urandom);
                in_tag = TW'($urandom);
            end
            out_ready = ($urandom % 4) != 0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", 64'(sent), 64'd10000);
        drain();
        check("rand_no_loss_dup", 64'(n_out), 64'(n_in));

        out_ready = 1'b0;
        send(32'd100, 32'd1, 1'b0, 4'd1);
        send(32'd200, 32'd2, 1'b0, 4'd2);
        send(32'd300, 32'd3, 1'b0, 4'd3);
        check("mid_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outputs", 64'({out_res, out_bout, out_ovf, out_zero, out_tag}), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int n = 0; n < 6; n++) begin
            cyc();
            stale = stale | out_valid;
        end
        check("mid_no_stale", 64'(stale), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        send(32'h1234_5678, 32'h0000_5678, 1'b1, 4'd9);
        cyc();
        check("mid_lat_not_yet", 64'(out_valid), 64'd0);
        cyc();
        check("mid_lat_three", 64'(out_valid), 64'd1);
        check("mid_res", 64'(out_res), 64'h1233_FFFF);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
